// File: rtl/mem_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - bus width of the core's native mem bus
//   - register map selected by addr[3:2] and STATUS bit positions
//   - transmit FSM state encoding
//   - bit_reload(): per-bit down-counter start value, max(div,1)-1
package mem_uart_tx_pkg;

    localparam int MEM_WIDTH = 32;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_DIV    = 2'd2,
        REG_UNUSED = 2'd3
    } uart_reg_e;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // A divisor of 0 behaves like 1, so every bit lasts at least one clock.
    function automatic logic [15:0] bit_reload(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/mem_uart_tx_fifo.sv
// Synchronous FIFO feeding the UART shifter (built only with MEM_UART_TX_FIFO_EN).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push, din   enqueue din (caller guarantees !full, or a pop in the same cycle)
//   pop, dout   dequeue; dout shows the head entry combinationally
//   full, empty occupancy flags (count == DEPTH / count == 0)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module mem_uart_tx_fifo
    import mem_uart_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // Push and pop together (even when full) leave the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mem_uart_tx.sv
// Memory-mapped UART transmitter on the core's native valid/ready mem bus.
// Bytes written to TXDATA are sent 8N1, LSB first, with a programmable divisor.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   valid      request (already address-selected by the interconnect)
//   ready      one-cycle completion pulse, the cycle after valid is sampled
//   wen[3:0]   byte write enables, 0 = read
//   addr       only addr[3:2] decoded: 0 TXDATA, 1 STATUS, 2 DIV, 3 unused
//   wdata      write data
//   rdata      read data, valid while ready=1
//   tx         serial line, idle high, registered
//   tx_busy    frame in flight or bytes queued
// Build option: define MEM_UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue;
// otherwise a single holding register sits between the bus and the shifter.
module mem_uart_tx
    import mem_uart_tx_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd104,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    output logic                 ready,
    input  logic [3:0]           wen,
    input  logic [MEM_WIDTH-1:0] addr,
    input  logic [MEM_WIDTH-1:0] wdata,
    output logic [MEM_WIDTH-1:0] rdata,
    output logic                 tx,
    output logic                 tx_busy
);
    uart_reg_e            reg_sel;
    logic                 is_write;
    logic                 txdata_push_req;
    logic                 accept;
    logic                 q_push;
    logic                 q_pop;
    logic                 q_full;
    logic                 q_empty;
    logic [7:0]           q_dout;
    logic [15:0]          div;
    logic [MEM_WIDTH-1:0] read_data;
    uart_state_e          state;
    uart_state_e          next_state;
    logic [15:0]          bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 bit_done;
    logic                 unused_ok;

    // ---------------- bus side ----------------
    assign reg_sel         = uart_reg_e'(addr[3:2]);
    assign is_write        = |wen;
    assign txdata_push_req = valid && !ready && wen[0] && (reg_sel == REG_TXDATA);
    // Gating on !ready keeps a held request from completing twice. A TXDATA
    // write into a full queue waits, and lands on the edge the shifter frees a slot.
    assign accept          = valid && !ready && (!txdata_push_req || !q_full || q_pop);
    assign q_push          = accept && txdata_push_req;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        read_data = '0;
        case (reg_sel)
            REG_STATUS: begin
                read_data[STATUS_EMPTY_BIT] = q_empty;
                read_data[STATUS_FULL_BIT]  = q_full;
                read_data[STATUS_BUSY_BIT]  = tx_busy;
            end
            REG_DIV: read_data[15:0] = div;
            default: read_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
            div   <= DEFAULT_DIV;
        end else begin
            ready <= accept;
            rdata <= (accept && !is_write) ? read_data : '0;
            if (accept && reg_sel == REG_DIV) begin
                if (wen[0]) div[7:0]  <= wdata[7:0];
                if (wen[1]) div[15:8] <= wdata[15:8];
            end
        end
    end

    // ---------------- byte queue ----------------
`ifdef MEM_UART_TX_FIFO_EN
    mem_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .din   (wdata[7:0]),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    assign unused_ok = &{1'b0, addr[31:4], addr[1:0], wdata[31:16]};
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    always_ff @(posedge clk) begin
        if (rst)         hold_valid <= 1'b0;
        else if (q_push) hold_valid <= 1'b1;
        else if (q_pop)  hold_valid <= 1'b0;
    end

    // NOTE: payload registers carry no reset; their valid flag decides whether they are read.
    always_ff @(posedge clk) begin
        if (q_push) hold_data <= wdata[7:0];
    end

    assign q_dout    = hold_data;
    assign q_full    = hold_valid;
    assign q_empty   = !hold_valid;
    assign unused_ok = &{1'b0, addr[31:4], addr[1:0], wdata[31:16], 1'(FIFO_DEPTH % 2)};
`endif

    // ---------------- transmit FSM ----------------
    assign bit_done = (bit_cnt == 16'd0);
    assign tx_busy  = (state != ST_IDLE) || !q_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        q_pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    q_pop      = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_START: if (bit_done) next_state = ST_DATA;
            ST_DATA:  if (bit_done && bit_idx == 3'd7) next_state = ST_STOP;
            ST_STOP: begin
                // Back-to-back bytes go straight from stop to the next start bit.
                if (bit_done) begin
                    if (!q_empty) begin
                        q_pop      = 1'b1;
                        next_state = ST_START;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // tx follows the state one clock later, so it comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            // DIV is sampled at each bit start, so a mid-frame write affects the next bit.
            if (q_pop || (state != ST_IDLE && bit_done)) bit_cnt <= bit_reload(div);
            else if (state != ST_IDLE)                    bit_cnt <= bit_cnt - 16'd1;

            if (state == ST_START)                bit_idx <= '0;
            else if (state == ST_DATA && bit_done) bit_idx <= bit_idx + 3'd1;

            case (state)
                ST_START: tx <= 1'b0;
                ST_DATA:  tx <= shift[0];
                default:  tx <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (q_pop)                             shift <= q_dout;
        else if (state == ST_DATA && bit_done) shift <= {1'b0, shift[7:1]};
    end

endmodule

// File: tb/tb_mem_uart_tx.sv
// Self-checking bench for mem_uart_tx: register-access vector table, a frame
// monitor fed by a scoreboard of written bytes, and hand sequences for
// latency, stalls, divisor 0 and reset in mid-frame.
module tb_mem_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;

    mem_uart_tx dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .ready   (ready),
        .wen     (wen),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    int         starts[$];
    int         mon_div  = 4;
    bit         mon_busy = 1'b0;
    int         last_ready_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after ready.
    task automatic bus(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
        valid = 1'b1; addr = a; wen = w; wdata = d; lat = 0; rd = '0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (ready) break;
            if (lat > 500) begin
                fail_now($sformatf("bus_timeout addr=0x%0h", a));
                break;
            end
        end
        rd = rdata;
        last_ready_cyc = cyc;
        if (ready && a[3:2] == 2'b00 && w[0]) sb.push_back(d[7:0]);
        valid = 1'b0; wen = 4'h0;
        @(posedge clk); #1;
        check("ready_single_pulse", 32'(ready), 32'd0);
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(sb.size() == 0 && !mon_busy && tx_busy == 1'b0)) begin
            @(posedge clk); #1;
            n++;
            if (n > budget) begin
                fail_now("wait_idle_timeout");
                break;
            end
        end
    endtask

    task automatic check_start(input string name, input int idx, input int exp);
        if (starts.size() > idx) check(name, 32'(starts[idx]), 32'(exp));
        else                     fail_now({name, "_missing_frame"});
    endtask

    // Frame monitor: every cycle of every bit must match the expected level.
    task automatic frame();
        logic [7:0] exp;
        logic [9:0] bits;
        int         d;
        int         nbad;
        mon_busy = 1'b1;
        d = mon_div;
        starts.push_back(cyc);
        if (sb.size() == 0) begin
            fail_now("unexpected_frame");
            exp = 8'h00;
        end else begin
            exp = sb.pop_front();
        end
        bits = {1'b1, exp, 1'b0};
        for (int k = 0; k < 10; k++) begin
            nbad = 0;
            for (int j = 0; j < d; j++) begin
                if (!(k == 0 && j == 0)) begin
                    @(negedge clk);
                    if (rst) begin
                        mon_busy = 1'b0;
                        return;
                    end
                end
                if (tx !== bits[k]) nbad++;
            end
            check($sformatf("frame_%02h_bit%0d_bad_cycles", exp, k), 32'(nbad), 32'd0);
        end
        mon_busy = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) frame();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        int          lat;
        int          t;
        int          idx;
        int          n0;

        vecs.push_back('{"rd_div_reset",     32'h8, 4'b0000, 32'h0,         1'b1, 32'h0000_0068});
        vecs.push_back('{"rd_status_reset",  32'h4, 4'b0000, 32'h0,         1'b1, 32'h0000_0004});
        vecs.push_back('{"rd_txdata",        32'h0, 4'b0000, 32'h0,         1'b1, 32'h0000_0000});
        vecs.push_back('{"rd_unused",        32'hC, 4'b0000, 32'h0,         1'b1, 32'h0000_0000});
        vecs.push_back('{"wr_div_lane0",     32'h8, 4'b0001, 32'h1234_56AB, 1'b0, 32'h0});
        vecs.push_back('{"rd_div_lane0",     32'h8, 4'b0000, 32'h0,         1'b1, 32'h0000_00AB});
        vecs.push_back('{"wr_div_lane1",     32'h8, 4'b0010, 32'hFFFF_0711, 1'b0, 32'h0});
        vecs.push_back('{"rd_div_lane1",     32'h8, 4'b0000, 32'h0,         1'b1, 32'h0000_07AB});
        vecs.push_back('{"wr_div_hi_lanes",  32'h8, 4'b1100, 32'hFFFF_FFFF, 1'b0, 32'h0});
        vecs.push_back('{"rd_div_hi_lanes",  32'h8, 4'b0000, 32'h0,         1'b1, 32'h0000_07AB});
        vecs.push_back('{"wr_status",        32'h4, 4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0});
        vecs.push_back('{"wr_unused",        32'hC, 4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0});
        vecs.push_back('{"rd_div_after_c",   32'h8, 4'b0000, 32'h0,         1'b1, 32'h0000_07AB});
        vecs.push_back('{"rd_status_after_c",32'h4, 4'b0000, 32'h0,         1'b1, 32'h0000_0004});
        vecs.push_back('{"wr_div_4",         32'h8, 4'b0011, 32'h0000_0004, 1'b0, 32'h0});
        vecs.push_back('{"rd_div_4",         32'h8, 4'b0000, 32'h0,         1'b1, 32'h0000_0004});

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);

        // ---- register table ----
        foreach (vecs[i]) begin
            bus(vecs[i].addr, vecs[i].wen, vecs[i].wdata, rd, lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'd1);
            if (vecs[i].chk_rd) check(vecs[i].name, rd, vecs[i].exp_rd);
        end
        check("table_no_frames", 32'(starts.size()), 32'd0);

        // ---- DIV=4, send 0x55 ----
        mon_div = 4;
        idx = starts.size();
        bus(32'h0, 4'b0001, 32'h0000_0055, rd, lat);
        t = last_ready_cyc;
        check("t1_latency", 32'(lat), 32'd1);
        goto_cycle(t + 40);
        check_start("t1_tx_fall_ready_plus2", idx, t + 2);
        check("t1_busy_before_end", 32'(tx_busy), 32'd1);
        goto_cycle(t + 41);
        check("t1_busy_falls", 32'(tx_busy), 32'd0);
        wait_idle(200);

        // ---- DIV=0 acts as 1: 10-clock frame ----
        bus(32'h8, 4'b0011, 32'h0000_0000, rd, lat);
        mon_div = 1;
        idx = starts.size();
        bus(32'h0, 4'b0001, 32'h0000_00FF, rd, lat);
        t = last_ready_cyc;
        goto_cycle(t + 10);
        check_start("t2_tx_fall", idx, t + 2);
        check("t2_busy_last_bit", 32'(tx_busy), 32'd1);
        goto_cycle(t + 11);
        check("t2_busy_after_10clk", 32'(tx_busy), 32'd0);
        wait_idle(100);
        bus(32'h8, 4'b0011, 32'h0000_0004, rd, lat);
        mon_div = 4;

`ifdef MEM_UART_TX_FIFO_EN
        // ---- FIFO: six back-to-back writes at DIV=8 ----
        bus(32'h8, 4'b0011, 32'h0000_0008, rd, lat);
        mon_div = 8;
        idx = starts.size();
        bus(32'h0, 4'b0001, 32'h0000_0001, rd, lat);
        t = last_ready_cyc;
        check("t3_w1_latency", 32'(lat), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            bus(32'h0, 4'b0001, 32'(k), rd, lat);
            check($sformatf("t3_w%0d_latency", k), 32'(lat), 32'd1);
        end
        bus(32'h4, 4'b0000, 32'h0, rd, lat);
        check("t3_status_full", rd, 32'h3);
        bus(32'h0, 4'b0001, 32'h0000_0006, rd, lat);
        check("t3_w6_ready_at_frame1_end", 32'(last_ready_cyc), 32'(t + 81));
        wait_idle(2000);
        check_start("t3_first_fall", idx, t + 2);
        for (int k = 0; k < 5; k++)
            if (starts.size() > idx + k + 1)
                check($sformatf("t3_gap_%0d", k), 32'(starts[idx+k+1] - starts[idx+k]), 32'd80);
            else
                fail_now($sformatf("t3_missing_frame_%0d", k + 1));
        bus(32'h8, 4'b0011, 32'h0000_0004, rd, lat);
        mon_div = 4;
`else
        // ---- holding register: write into an occupied slot stalls ----
        idx = starts.size();
        bus(32'h0, 4'b0001, 32'h0000_0011, rd, lat);
        t = last_ready_cyc;
        bus(32'h0, 4'b0001, 32'h0000_0022, rd, lat);
        check("t4_second_latency", 32'(lat), 32'd1);
        bus(32'h4, 4'b0000, 32'h0, rd, lat);
        check("t4_status_occupied_busy", rd, 32'h3);
        bus(32'h0, 4'b0001, 32'h0000_0033, rd, lat);
        check("t4_stalled_ready_at_frame1_end", 32'(last_ready_cyc), 32'(t + 41));
        wait_idle(500);
        check_start("t4_first_fall", idx, t + 2);
        for (int k = 0; k < 2; k++)
            if (starts.size() > idx + k + 1)
                check($sformatf("t4_gap_%0d", k), 32'(starts[idx+k+1] - starts[idx+k]), 32'd40);
            else
                fail_now($sformatf("t4_missing_frame_%0d", k + 1));
`endif

        // ---- reset in the middle of a data bit of 0xA5, with a byte queued ----
        bus(32'h0, 4'b0001, 32'h0000_00A5, rd, lat);
        t = last_ready_cyc;
        bus(32'h0, 4'b0001, 32'h0000_003C, rd, lat);
        goto_cycle(t + 12);
        check("t5_tx_low_data_bit1", 32'(tx), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_tx_high_after_rst", 32'(tx), 32'd1);
        check("t5_busy_after_rst", 32'(tx_busy), 32'd0);
        check("t5_ready_after_rst", 32'(ready), 32'd0);
        rst = 1'b0;
        sb.delete();
        bus(32'h4, 4'b0000, 32'h0, rd, lat);
        check("t5_status", rd, 32'h4);
        bus(32'h8, 4'b0000, 32'h0, rd, lat);
        check("t5_div", rd, 32'h68);
        n0 = starts.size();
        repeat (150) @(posedge clk);
        #1;
        check("t5_no_further_frame", 32'(starts.size()), 32'(n0));
        check("t5_tx_idle", 32'(tx), 32'd1);
        check("end_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
